exec_arith_unit: RTL and testbench

Integer arithmetic core of the execute stage. It combines a RV64I ALU and a RV64M multiply/divide unit behind one operand pair and selects between them. It produces a zero-latency combinational result, used for forwarding, and a one-stage registered copy, used by the EX/MEM pipeline register. Word-mode (`*W`) operations are supported via a 32-bit truncate/sign-extend flag.

---
 rtl/exec_arith_unit.sv | 116 +++++++++++
 tb/tb_exec_arith_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exec_arith_unit.sv
// Execute-stage integer core: RV64I ALU plus optional RV64M mul/div (EXEC_MULDIV_EN), 0-cycle result and a registered copy.
// Latency 0 on result, 1 on out_result/out_valid; hold freezes the output register, no other backpressure.
module exec_arith_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        in_valid,
  input  logic [63:0] ia,
  input  logic [63:0] ib,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  mul_op,
  input  logic        rvm,
  input  logic        rv64,
  output logic [63:0] result,
  output logic        out_valid,
  output logic [63:0] out_result
);

  logic [5:0]  shamt;
  logic [63:0] srl_src;
  logic [63:0] sra_src;
  logic [63:0] alu;
  logic [63:0] muldiv;
  logic [63:0] sel;

  // Word-mode right shifts operate on the low word only, so pre-extend it.
  assign shamt   = rv64 ? {1'b0, ib[4:0]} : ib[5:0];
  assign srl_src = rv64 ? {32'b0, ia[31:0]} : ia;
  assign sra_src = rv64 ? {{32{ia[31]}}, ia[31:0]} : ia;

  always_comb begin
    alu = '0;
    case (alu_op)
      4'd0:    alu = ia + ib;
      4'd1:    alu = ia - ib;
      4'd2:    alu = ia << shamt;
      4'd3:    alu = {63'b0, $signed(ia) < $signed(ib)};
      4'd4:    alu = {63'b0, ia < ib};
      4'd5:    alu = ia ^ ib;
      4'd6:    alu = srl_src >> shamt;
      4'd7:    alu = $signed(sra_src) >>> shamt;
      4'd8:    alu = ia | ib;
      4'd9:    alu = ia & ib;
      4'd10:   alu = ib;
      default: alu = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  logic          a_mul_signed;
  logic          b_mul_signed;
  logic [127:0]  prod;
  logic          div_signed;
  logic [63:0]   dvd;
  logic [63:0]   dvs;
  logic          a_neg;
  logic          b_neg;
  logic [63:0]   a_mag;
  logic [63:0]   b_mag;
  logic [63:0]   q_mag;
  logic [63:0]   r_mag;
  logic [63:0]   quot;
  logic [63:0]   rem;

  assign a_mul_signed = (mul_op == 3'd1) || (mul_op == 3'd2);
  assign b_mul_signed = (mul_op == 3'd1);
  assign prod = {{64{a_mul_signed & ia[63]}}, ia} * {{64{b_mul_signed & ib[63]}}, ib};

  // Word-mode operands are widened to 64 bits so one divider covers both
  // widths; the 32-bit overflow and divide-by-zero corners fall out after sext.
  assign div_signed = ~mul_op[0];
  assign dvd = rv64 ? {{32{div_signed & ia[31]}}, ia[31:0]} : ia;
  assign dvs = rv64 ? {{32{div_signed & ib[31]}}, ib[31:0]} : ib;
  assign a_neg = div_signed & dvd[63];
  assign b_neg = div_signed & dvs[63];
  assign a_mag = a_neg ? -dvd : dvd;
  assign b_mag = b_neg ? -dvs : dvs;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;

  // Most-negative / -1 needs no special case: the magnitude path wraps back to the dividend.
  assign quot = (dvs == 64'd0) ? '1  : ((a_neg ^ b_neg) ? -q_mag : q_mag);
  assign rem  = (dvs == 64'd0) ? dvd : (a_neg ? -r_mag : r_mag);

  always_comb begin
    muldiv = '0;
    case (mul_op)
      3'd0:    muldiv = prod[63:0];
      3'd1,
      3'd2,
      3'd3:    muldiv = prod[127:64];
      3'd4,
      3'd5:    muldiv = quot;
      default: muldiv = rem;
    endcase
  end
`else
  logic unused_mul_op;
  assign unused_mul_op = ^mul_op;
  assign muldiv = '0;
`endif

  assign sel    = rvm ? muldiv : alu;
  assign result = rv64 ? {{32{sel[31]}}, sel[31:0]} : sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (!hold) begin
      out_valid  <= in_valid;
      out_result <= result;
    end
  end

endmodule

// File: tb/tb_exec_arith_unit.sv
// Directed bench for exec_arith_unit: expected values queued at drive time, popped at the observation point.
module tb_exec_arith_unit;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        in_valid;
  logic [63:0] ia;
  logic [63:0] ib;
  logic [3:0]  alu_op;
  logic [2:0]  mul_op;
  logic        rvm;
  logic        rv64;
  logic [63:0] result;
  logic        out_valid;
  logic [63:0] out_result;

  int total = 0;
  int bad   = 0;
  logic [63:0] expq[$];

  exec_arith_unit dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .in_valid   (in_valid),
    .ia         (ia),
    .ib         (ib),
    .alu_op     (alu_op),
    .mul_op     (mul_op),
    .rvm        (rvm),
    .rv64       (rv64),
    .result     (result),
    .out_valid  (out_valid),
    .out_result (out_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Mul/div expectations collapse to 0 when the unit is built out.
  function automatic logic [63:0] md(input logic [63:0] v);
`ifdef EXEC_MULDIV_EN
    return v;
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = expq.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic op(input string tag, input logic [3:0] a_op, input logic [2:0] m_op,
                    input logic m, input logic w, input logic [63:0] a, input logic [63:0] b,
                    input logic [63:0] exp);
    alu_op = a_op;
    mul_op = m_op;
    rvm    = m;
    rv64   = w;
    ia     = a;
    ib     = b;
    expq.push_back(exp);
    #1;
    chk(tag, result);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; in_valid = 1'b0;
    ia = '0; ib = '0; alu_op = '0; mul_op = '0; rvm = 1'b0; rv64 = 1'b0;
    #2;
    expq.push_back(64'd0); chk("reset_out_result", out_result);
    expq.push_back(64'd0); chk("reset_out_valid", {63'b0, out_valid});
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b1;

    // ALU, 64-bit and word mode
    op("add",      4'd0, 3'd0, 0, 0, 64'd5, -64'sd3, 64'd2);
    op("addw",     4'd0, 3'd0, 0, 1, 64'h7FFFFFFF, 64'd1, 64'hFFFFFFFF80000000);
    op("sub",      4'd1, 3'd0, 0, 0, 64'd3, 64'd5, 64'hFFFFFFFFFFFFFFFE);
    op("sll63",    4'd2, 3'd0, 0, 0, 64'd1, 64'd63, 64'h8000000000000000);
    op("sll_mask", 4'd2, 3'd0, 0, 0, 64'd1, 64'h41, 64'd2);
    op("sllw31",   4'd2, 3'd0, 0, 1, 64'd1, 64'd31, 64'hFFFFFFFF80000000);
    op("sllw_msk", 4'd2, 3'd0, 0, 1, 64'd1, 64'd33, 64'd2);
    op("slt",      4'd3, 3'd0, 0, 0, -64'sd1, 64'd1, 64'd1);
    op("sltu",     4'd4, 3'd0, 0, 0, -64'sd1, 64'd1, 64'd0);
    op("xor",      4'd5, 3'd0, 0, 0, 64'hF0F0, 64'hFF00, 64'h0FF0);
    op("srl",      4'd6, 3'd0, 0, 0, 64'h8000000000000000, 64'd4, 64'h0800000000000000);
    op("srlw",     4'd6, 3'd0, 0, 1, 64'hFFFFFFFF80000000, 64'd4, 64'h0000000008000000);
    op("sra",      4'd7, 3'd0, 0, 0, 64'h8000000000000000, 64'd4, 64'hF800000000000000);
    op("sraw",     4'd7, 3'd0, 0, 1, 64'h80000000, 64'd4, 64'hFFFFFFFFF8000000);
    op("or",       4'd8, 3'd0, 0, 0, 64'hF000, 64'h000F, 64'hF00F);
    op("and",      4'd9, 3'd0, 0, 0, 64'hFF0F, 64'h0FF0, 64'h0F00);
    op("passb",    4'd10, 3'd7, 0, 0, 64'd9, 64'h1234, 64'h1234);
    op("op12",     4'd12, 3'd0, 0, 0, 64'd9, 64'd9, 64'd0);

    // Multiply
    op("mulhu",    4'd0, 3'd3, 1, 0, 64'hFFFFFFFFFFFFFFFF, 64'd2, md(64'd1));
    op("mulh",     4'd0, 3'd1, 1, 0, -64'sd1, -64'sd1, md(64'd0));
    op("mul",      4'd0, 3'd0, 1, 0, 64'd3, -64'sd4, md(64'hFFFFFFFFFFFFFFF4));
    op("mulhsu",   4'd0, 3'd2, 1, 0, -64'sd1, 64'd2, md(64'hFFFFFFFFFFFFFFFF));
    op("mulw",     4'd0, 3'd0, 1, 1, 64'h10000, 64'h18000, md(64'hFFFFFFFF80000000));
    op("mul_3x4",  4'd0, 3'd0, 1, 0, 64'd3, 64'd4, md(64'd12));

    // Divide corners
    op("div_by0",  4'd0, 3'd4, 1, 0, 64'd7, 64'd0, md(64'hFFFFFFFFFFFFFFFF));
    op("rem_by0",  4'd0, 3'd6, 1, 0, 64'd7, 64'd0, md(64'd7));
    op("div_ovf",  4'd0, 3'd4, 1, 0, 64'h8000000000000000, -64'sd1, md(64'h8000000000000000));
    op("rem_ovf",  4'd0, 3'd6, 1, 0, 64'h8000000000000000, -64'sd1, md(64'd0));
    op("div_neg",  4'd0, 3'd4, 1, 0, -64'sd7, 64'd2, md(64'hFFFFFFFFFFFFFFFD));
    op("rem_neg",  4'd0, 3'd6, 1, 0, -64'sd7, 64'd2, md(64'hFFFFFFFFFFFFFFFF));
    op("divu_by0", 4'd0, 3'd5, 1, 0, 64'd7, 64'd0, md(64'hFFFFFFFFFFFFFFFF));
    op("remu",     4'd0, 3'd7, 1, 0, 64'hFFFFFFFFFFFFFFFF, 64'd16, md(64'd15));
    op("divu_big", 4'd0, 3'd5, 1, 0, 64'hFFFFFFFFFFFFFFFF, 64'd2, md(64'h7FFFFFFFFFFFFFFF));
    op("divw_ovf", 4'd0, 3'd4, 1, 1, 64'h80000000, 64'hFFFFFFFF, md(64'hFFFFFFFF80000000));
    op("remw_ovf", 4'd0, 3'd6, 1, 1, 64'h80000000, 64'hFFFFFFFF, md(64'd0));
    op("divuw0",   4'd0, 3'd5, 1, 1, 64'hFFFFFFFF, 64'd0, md(64'hFFFFFFFFFFFFFFFF));
    op("divuw",    4'd0, 3'd5, 1, 1, 64'h80000000, 64'd2, md(64'h40000000));
    op("divw_neg", 4'd0, 3'd4, 1, 1, 64'h12345678FFFFFFF9, 64'd2, md(64'hFFFFFFFFFFFFFFFD));
    op("remuw0",   4'd0, 3'd7, 1, 1, 64'h00000000F0000001, 64'd0, md(64'hFFFFFFFFF0000001));

    // Output register, hold and asynchronous reset
    @(negedge clk);
    hold = 1'b0; in_valid = 1'b1;
    alu_op = 4'd0; mul_op = 3'd0; rvm = 1'b0; rv64 = 1'b0; ia = 64'd1; ib = 64'd1;
    @(posedge clk); #1;
    expq.push_back(64'd2); chk("reg_add_res", out_result);
    expq.push_back(64'd1); chk("reg_add_vld", {63'b0, out_valid});

    @(negedge clk);
    hold = 1'b1; in_valid = 1'b0; ia = 64'd100; ib = 64'd1;
    repeat (2) @(posedge clk);
    #1;
    expq.push_back(64'd2); chk("hold_res", out_result);
    expq.push_back(64'd1); chk("hold_vld", {63'b0, out_valid});

    @(negedge clk);
    hold = 1'b0;
    @(posedge clk); #1;
    expq.push_back(64'd101); chk("capture_invalid_res", out_result);
    expq.push_back(64'd0);   chk("capture_invalid_vld", {63'b0, out_valid});

    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    expq.push_back(64'd1); chk("revalid_vld", {63'b0, out_valid});

    @(negedge clk);
    rst = 1'b1; hold = 1'b1;
    #1;
    expq.push_back(64'd0);   chk("async_rst_res", out_result);
    expq.push_back(64'd0);   chk("async_rst_vld", {63'b0, out_valid});
    expq.push_back(64'd101); chk("rst_comb_result", result);
    hold = 1'b0;
    @(posedge clk); #1;
    expq.push_back(64'd0); chk("rst_over_edge_res", out_result);

    @(negedge clk);
    rst = 1'b0; ia = 64'd5; ib = 64'd6;
    @(posedge clk); #1;
    expq.push_back(64'd11); chk("post_rst_res", out_result);
    expq.push_back(64'd1);  chk("post_rst_vld", {63'b0, out_valid});

    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover count=%0d expected=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
